// File: rtl/tl_cpl_pkg.sv
// Shared types and helpers for the completion tracker.
package tl_cpl_pkg;

  localparam logic [2:0] CPL_SC = 3'b000;

  typedef struct packed {
    logic len_overflow;
    logic id_mismatch;
    logic bad_status;
  } cpl_err_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    CHECK  = 2'd2,
    OUT    = 2'd3
  } cpl_state_e;

  // A 10-bit DW length of zero encodes 1024 DW.
  function automatic logic [10:0] dw_decode(input logic [9:0] len10);
    return (len10 == 10'd0) ? 11'd1024 : {1'b0, len10};
  endfunction

endpackage

// File: rtl/tl_cpl_remaining_ram.sv
// Per-tag remaining-DW store: alloc write port plus a CHECK read/modify-write port.
module tl_cpl_remaining_ram #(
  parameter int TAG_W = 8,
  parameter int DEPTH = 1 << TAG_W
) (
  input  logic             clk,
  input  logic             alloc_we,
  input  logic [TAG_W-1:0] alloc_addr,
  input  logic [10:0]      alloc_data,
  input  logic [TAG_W-1:0] rmw_addr,
  output logic [10:0]      rmw_rdata,
  input  logic             rmw_we,
  input  logic [10:0]      rmw_wdata
);

  logic [10:0] mem [DEPTH];
  logic        collide;

  assign rmw_rdata = mem[rmw_addr];
  assign collide   = alloc_we && (alloc_addr == rmw_addr);

  // The alloc snoop owns the entry when both ports hit the same tag.
  always_ff @(posedge clk) begin
    if (alloc_we) begin
      mem[alloc_addr] <= alloc_data;
    end
    if (rmw_we && !collide) begin
      mem[rmw_addr] <= rmw_wdata;
    end
  end

endmodule

// File: rtl/tl_cpl_tracker.sv
// Completion receive engine: tag lookup, status/ID/length checks, tag free.
// Optional saturating error counters are built when TL_CPL_ERR_CNT_EN is defined.
//
// state  | meaning
// IDLE   | ready to accept a completion header
// LOOKUP | waiting for the tag table to return metadata
// CHECK  | checks run, remaining count and bitmap updated
// OUT    | descriptor held until consumed
module tl_cpl_tracker
  import tl_cpl_pkg::*;
#(
  parameter int TAG_W = 8,
  parameter int DEPTH = 1 << TAG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alloc_fire_i,
  input  logic [TAG_W-1:0] alloc_tag_i,
  input  logic [9:0]       alloc_len_i,
  input  logic             cpl_valid_i,
  output logic             cpl_ready_o,
  input  logic [TAG_W-1:0] cpl_tag_i,
  input  logic [15:0]      cpl_req_id_i,
  input  logic [2:0]       cpl_status_i,
  input  logic [9:0]       cpl_len_i,
  output logic [TAG_W-1:0] lookup_tag_o,
  output logic             lookup_valid_o,
  input  logic             lookup_ready_i,
  input  logic [15:0]      tt_req_id_i,
  input  logic [31:0]      tt_addr_i,
  input  logic [9:0]       tt_len_i,
  input  logic [2:0]       tt_attr_i,
  output logic [TAG_W-1:0] free_tag_o,
  output logic             free_valid_o,
`ifdef TL_CPL_ERR_CNT_EN
  input  logic             err_cnt_clr_i,
  output logic [15:0]      err_cnt_status_o,
  output logic [15:0]      err_cnt_id_o,
  output logic [15:0]      err_cnt_len_o,
  output logic [15:0]      err_cnt_unexp_o,
`endif
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [TAG_W-1:0] out_tag_o,
  output logic [31:0]      out_addr_o,
  output logic [2:0]       out_attr_o,
  output logic [9:0]       out_len_o,
  output logic             out_last_o,
  output logic [2:0]       out_err_o,
  output logic             out_unexp_o
);

  cpl_state_e       state_q, state_d;
  logic             rdy_q;
  logic [TAG_W-1:0] cap_tag_q;
  logic [15:0]      cap_req_id_q;
  logic [2:0]       cap_status_q;
  logic [9:0]       cap_len_q;
  logic [15:0]      tt_req_id_q;
  logic [31:0]      tt_addr_q;
  logic [2:0]       tt_attr_q;
  logic [DEPTH-1:0] outstanding_q;

  logic             accept;
  logic             lookup_done;
  logic             in_check;
  logic             hit;
  logic [10:0]      dec_len;
  logic [10:0]      rem_rd;
  logic [10:0]      rem_nxt;
  cpl_err_t         err;
  logic             any_err;
  logic             chk_last;
  logic             rem_we;

  // The table length field carries no information the checks need.
  logic             unused_tt_len;
  assign unused_tt_len = ^tt_len_i;

  assign accept      = (state_q == IDLE) && rdy_q && cpl_valid_i;
  assign lookup_done = (state_q == LOOKUP) && lookup_ready_i;
  assign in_check    = (state_q == CHECK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= (state_d == IDLE);
    end
  end

  always_comb begin
    state_d        = state_q;
    lookup_valid_o = 1'b0;
    out_valid_o    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) state_d = LOOKUP;
      end
      LOOKUP: begin
        lookup_valid_o = 1'b1;
        if (lookup_ready_i) state_d = CHECK;
      end
      CHECK: begin
        state_d = OUT;
      end
      OUT: begin
        out_valid_o = 1'b1;
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Ready is registered so it stays low while reset is asserted.
  assign cpl_ready_o  = rdy_q;
  assign lookup_tag_o = cap_tag_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_tag_q    <= '0;
      cap_req_id_q <= '0;
      cap_status_q <= '0;
      cap_len_q    <= '0;
      tt_req_id_q  <= '0;
      tt_addr_q    <= '0;
      tt_attr_q    <= '0;
    end else begin
      if (accept) begin
        cap_tag_q    <= cpl_tag_i;
        cap_req_id_q <= cpl_req_id_i;
        cap_status_q <= cpl_status_i;
        cap_len_q    <= cpl_len_i;
      end
      if (lookup_done) begin
        tt_req_id_q <= tt_req_id_i;
        tt_addr_q   <= tt_addr_i;
        tt_attr_q   <= tt_attr_i;
      end
    end
  end

  tl_cpl_remaining_ram #(
    .TAG_W (TAG_W),
    .DEPTH (DEPTH)
  ) u_rem (
    .clk        (clk),
    .alloc_we   (alloc_fire_i),
    .alloc_addr (alloc_tag_i),
    .alloc_data (dw_decode(alloc_len_i)),
    .rmw_addr   (cap_tag_q),
    .rmw_rdata  (rem_rd),
    .rmw_we     (rem_we),
    .rmw_wdata  (rem_nxt)
  );

  assign hit     = outstanding_q[cap_tag_q];
  assign dec_len = dw_decode(cap_len_q);
  assign rem_nxt = rem_rd - dec_len;

  // Unexpected completions report no error bits and touch no state.
  always_comb begin
    err = '0;
    if (hit) begin
      err.bad_status   = (cap_status_q != CPL_SC);
      err.id_mismatch  = (cap_req_id_q != tt_req_id_q);
      err.len_overflow = (dec_len > rem_rd);
    end
  end

  assign any_err  = |err;
  assign chk_last = hit && (any_err || (rem_nxt == 11'd0));
  assign rem_we   = in_check && hit && !any_err;

  // Later assignment wins, so an alloc snoop on the same tag keeps the bit set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding_q <= '0;
    end else begin
      if (in_check && chk_last) outstanding_q[cap_tag_q] <= 1'b0;
      if (alloc_fire_i)         outstanding_q[alloc_tag_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      free_valid_o <= 1'b0;
      free_tag_o   <= '0;
      out_tag_o    <= '0;
      out_addr_o   <= '0;
      out_attr_o   <= '0;
      out_len_o    <= '0;
      out_last_o   <= 1'b0;
      out_err_o    <= '0;
      out_unexp_o  <= 1'b0;
    end else begin
      free_valid_o <= in_check && chk_last;
      if (in_check && chk_last) free_tag_o <= cap_tag_q;
      if (in_check) begin
        out_tag_o   <= cap_tag_q;
        out_addr_o  <= tt_addr_q;
        out_attr_o  <= tt_attr_q;
        out_len_o   <= cap_len_q;
        out_last_o  <= chk_last;
        out_err_o   <= err;
        out_unexp_o <= !hit;
      end
    end
  end

`ifdef TL_CPL_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_status_o <= '0;
      err_cnt_id_o     <= '0;
      err_cnt_len_o    <= '0;
      err_cnt_unexp_o  <= '0;
    end else if (err_cnt_clr_i) begin
      err_cnt_status_o <= '0;
      err_cnt_id_o     <= '0;
      err_cnt_len_o    <= '0;
      err_cnt_unexp_o  <= '0;
    end else if (in_check) begin
      if (err.bad_status && (err_cnt_status_o != 16'hFFFF))
        err_cnt_status_o <= err_cnt_status_o + 16'd1;
      if (err.id_mismatch && (err_cnt_id_o != 16'hFFFF))
        err_cnt_id_o <= err_cnt_id_o + 16'd1;
      if (err.len_overflow && (err_cnt_len_o != 16'hFFFF))
        err_cnt_len_o <= err_cnt_len_o + 16'd1;
      if (!hit && (err_cnt_unexp_o != 16'hFFFF))
        err_cnt_unexp_o <= err_cnt_unexp_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tl_cpl_tracker.sv
// Scoreboard bench for tl_cpl_tracker: expected descriptors queued at stimulus, popped at output.
module tb_tl_cpl_tracker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alloc_fire = 1'b0;
  logic [7:0]  alloc_tag = '0;
  logic [9:0]  alloc_len = '0;
  logic        cpl_valid = 1'b0;
  logic        cpl_ready_o;
  logic [7:0]  cpl_tag = '0;
  logic [15:0] cpl_req_id = '0;
  logic [2:0]  cpl_status = '0;
  logic [9:0]  cpl_len = '0;
  logic [7:0]  lookup_tag_o;
  logic        lookup_valid_o;
  logic        lookup_ready = 1'b1;
  logic [15:0] tt_req_id = '0;
  logic [31:0] tt_addr = '0;
  logic [9:0]  tt_len = '0;
  logic [2:0]  tt_attr = '0;
  logic [7:0]  free_tag_o;
  logic        free_valid_o;
  logic        out_valid_o;
  logic        out_ready = 1'b0;
  logic [7:0]  out_tag_o;
  logic [31:0] out_addr_o;
  logic [2:0]  out_attr_o;
  logic [9:0]  out_len_o;
  logic        out_last_o;
  logic [2:0]  out_err_o;
  logic        out_unexp_o;
`ifdef TL_CPL_ERR_CNT_EN
  logic        err_cnt_clr = 1'b0;
  logic [15:0] err_cnt_status_o, err_cnt_id_o, err_cnt_len_o, err_cnt_unexp_o;
`endif

  always #5 clk = ~clk;

  tl_cpl_tracker #(.TAG_W(8), .DEPTH(256)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .alloc_fire_i   (alloc_fire),
    .alloc_tag_i    (alloc_tag),
    .alloc_len_i    (alloc_len),
    .cpl_valid_i    (cpl_valid),
    .cpl_ready_o    (cpl_ready_o),
    .cpl_tag_i      (cpl_tag),
    .cpl_req_id_i   (cpl_req_id),
    .cpl_status_i   (cpl_status),
    .cpl_len_i      (cpl_len),
    .lookup_tag_o   (lookup_tag_o),
    .lookup_valid_o (lookup_valid_o),
    .lookup_ready_i (lookup_ready),
    .tt_req_id_i    (tt_req_id),
    .tt_addr_i      (tt_addr),
    .tt_len_i       (tt_len),
    .tt_attr_i      (tt_attr),
    .free_tag_o     (free_tag_o),
    .free_valid_o   (free_valid_o),
`ifdef TL_CPL_ERR_CNT_EN
    .err_cnt_clr_i    (err_cnt_clr),
    .err_cnt_status_o (err_cnt_status_o),
    .err_cnt_id_o     (err_cnt_id_o),
    .err_cnt_len_o    (err_cnt_len_o),
    .err_cnt_unexp_o  (err_cnt_unexp_o),
`endif
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready),
    .out_tag_o      (out_tag_o),
    .out_addr_o     (out_addr_o),
    .out_attr_o     (out_attr_o),
    .out_len_o      (out_len_o),
    .out_last_o     (out_last_o),
    .out_err_o      (out_err_o),
    .out_unexp_o    (out_unexp_o)
  );

  typedef struct {
    logic [7:0]  tag;
    logic [31:0] addr;
    logic [2:0]  attr;
    logic [9:0]  len;
    logic        last;
    logic [2:0]  err;
    logic        unexp;
    logic        free;
  } exp_t;

  exp_t sb[$];
  bit   m_out [256];
  int   m_rem [256];
  int   n_status = 0, n_id = 0, n_len = 0, n_unexp = 0;
  int   vectors = 0;
  int   miscompares = 0;

  function automatic int dec(input logic [9:0] l);
    return (l == 10'd0) ? 1024 : int'(l);
  endfunction

  task automatic do_alloc(input logic [7:0] tag, input logic [9:0] len);
    @(negedge clk);
    alloc_fire = 1'b1; alloc_tag = tag; alloc_len = len;
    @(negedge clk);
    alloc_fire = 1'b0;
    m_out[tag] = 1'b1;
    m_rem[tag] = dec(len);
  endtask

  task automatic send_cpl(input logic [7:0] tag, input logic [15:0] rid, input logic [2:0] st,
                          input logic [9:0] len, input logic [15:0] tid, input logic [31:0] addr,
                          input logic [2:0] attr, input int hold, input string name);
    exp_t e;
    int n, frees;
    logic [7:0] ftag;
    logic [57:0] got, want;
    e.tag = tag; e.addr = addr; e.attr = attr; e.len = len;
    e.last = 1'b0; e.err = 3'b000; e.unexp = 1'b0; e.free = 1'b0;
    if (!m_out[tag]) begin
      e.unexp = 1'b1;
      n_unexp++;
    end else begin
      e.err[2] = dec(len) > m_rem[tag];
      e.err[1] = rid != tid;
      e.err[0] = st != 3'b000;
      n_len += int'(e.err[2]); n_id += int'(e.err[1]); n_status += int'(e.err[0]);
      if (e.err != 3'b000) e.last = 1'b1;
      else begin
        m_rem[tag] -= dec(len);
        e.last = (m_rem[tag] == 0);
      end
      if (e.last) begin e.free = 1'b1; m_out[tag] = 1'b0; end
    end
    sb.push_back(e);

    @(negedge clk);
    cpl_valid = 1'b1; cpl_tag = tag; cpl_req_id = rid; cpl_status = st; cpl_len = len;
    tt_req_id = tid; tt_addr = addr; tt_attr = attr; tt_len = len;
    n = 0;
    while (cpl_ready_o !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      vectors++; miscompares++;
      $display("FAIL %s accept: cpl_ready_o never rose", name);
      cpl_valid = 1'b0; void'(sb.pop_back());
      return;
    end
    @(negedge clk);
    cpl_valid = 1'b0;
    vectors++;
    if ({lookup_valid_o, lookup_tag_o} !== {1'b1, tag}) begin
      miscompares++;
      $display("FAIL %s lookup: got valid=%0b tag=%0h want valid=1 tag=%0h", name, lookup_valid_o, lookup_tag_o, tag);
    end
    frees = 0; ftag = '0; n = 0;
    while (out_valid_o !== 1'b1 && n < 50) begin
      if (free_valid_o === 1'b1) frees++;
      @(negedge clk); n++;
    end
    e = sb.pop_front();
    if (n >= 50) begin
      vectors++; miscompares++;
      $display("FAIL %s out_valid: never asserted", name);
      return;
    end
    if (free_valid_o === 1'b1) begin frees++; ftag = free_tag_o; end
    if (lookup_ready === 1'b1) begin
      vectors++;
      if (n !== 2) begin
        miscompares++;
        $display("FAIL %s latency: got %0d cycles after lookup want 2", name, n);
      end
    end
    want = {e.tag, e.addr, e.attr, e.len, e.last, e.err, e.unexp};
    got  = {out_tag_o, out_addr_o, out_attr_o, out_len_o, out_last_o, out_err_o, out_unexp_o};
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s desc: got last=%0b err=%03b unexp=%0b {%h} want last=%0b err=%03b unexp=%0b {%h}",
               name, out_last_o, out_err_o, out_unexp_o, got, e.last, e.err, e.unexp, want);
    end
    vectors++;
    if (frees !== int'(e.free) || (e.free && ftag !== e.tag)) begin
      miscompares++;
      $display("FAIL %s free: got %0d pulses tag=%0h want %0d pulses tag=%0h", name, frees, ftag, int'(e.free), e.tag);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      vectors++;
      if ({out_valid_o, cpl_ready_o, free_valid_o, got} !== {3'b100, want}) begin
        miscompares++;
        $display("FAIL %s hold%0d: got v=%0b rdy=%0b free=%0b {%h} want v=1 rdy=0 free=0 {%h}",
                 name, i, out_valid_o, cpl_ready_o, free_valid_o,
                 {out_tag_o, out_addr_o, out_attr_o, out_len_o, out_last_o, out_err_o, out_unexp_o}, want);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    vectors++;
    if ({out_valid_o, cpl_ready_o, free_valid_o} !== 3'b010) begin
      miscompares++;
      $display("FAIL %s release: got v=%0b rdy=%0b free=%0b want v=0 rdy=1 free=0", name, out_valid_o, cpl_ready_o, free_valid_o);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({cpl_ready_o, lookup_valid_o, free_valid_o, out_valid_o, out_last_o, out_err_o, out_unexp_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got rdy=%0b lkv=%0b free=%0b v=%0b want all 0", cpl_ready_o, lookup_valid_o, free_valid_o, out_valid_o);
    end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (cpl_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: got %0b want 1", cpl_ready_o);
    end
  endtask

  task automatic test_single;
    do_alloc(8'd5, 10'd8);
    send_cpl(8'd5, 16'h1234, 3'b000, 10'd8, 16'h1234, 32'hDEAD_BEE0, 3'b101, 0, "single");
  endtask

  task automatic test_multi;
    do_alloc(8'd3, 10'd16);
    send_cpl(8'd3, 16'h0100, 3'b000, 10'd4, 16'h0100, 32'h1000_0000, 3'b001, 0, "multi_a");
    send_cpl(8'd3, 16'h0100, 3'b000, 10'd4, 16'h0100, 32'h1000_0000, 3'b001, 0, "multi_b");
    send_cpl(8'd3, 16'h0100, 3'b000, 10'd8, 16'h0100, 32'h1000_0000, 3'b001, 0, "multi_c");
  endtask

  task automatic test_1024;
    do_alloc(8'd7, 10'd0);
    send_cpl(8'd7, 16'hABCD, 3'b000, 10'd0, 16'hABCD, 32'h8000_0004, 3'b010, 0, "len1024");
  endtask

  task automatic test_unexp;
    do_alloc(8'd12, 10'd8);
    send_cpl(8'd9, 16'h0001, 3'b000, 10'd4, 16'h0001, 32'h0000_0090, 3'b000, 0, "unexp_a");
    send_cpl(8'd12, 16'h0002, 3'b000, 10'd8, 16'h0002, 32'h0000_00C0, 3'b000, 0, "unexp_other");
    send_cpl(8'd9, 16'h0001, 3'b000, 10'd4, 16'h0001, 32'h0000_0090, 3'b000, 0, "unexp_b");
    send_cpl(8'd5, 16'h1234, 3'b000, 10'd8, 16'h1234, 32'hDEAD_BEE0, 3'b000, 0, "unexp_freed");
  endtask

  task automatic test_errors;
    do_alloc(8'd2, 10'd4);
    send_cpl(8'd2, 16'h0200, 3'b000, 10'd8, 16'h0200, 32'h2000_0000, 3'b000, 0, "err_len");
    do_alloc(8'd2, 10'd4);
    send_cpl(8'd2, 16'h0200, 3'b001, 10'd4, 16'h0200, 32'h2000_0040, 3'b000, 0, "err_status");
    send_cpl(8'd2, 16'h0200, 3'b000, 10'd4, 16'h0200, 32'h2000_0040, 3'b000, 0, "err_after_free");
    do_alloc(8'd4, 10'd16);
    send_cpl(8'd4, 16'h0400, 3'b000, 10'd4, 16'h0401, 32'h4000_0000, 3'b011, 0, "err_id");
  endtask

  task automatic test_backpressure;
    do_alloc(8'd6, 10'd2);
    send_cpl(8'd6, 16'h0600, 3'b000, 10'd1, 16'h0600, 32'h6000_0000, 3'b110, 10, "hold");
  endtask

  task automatic test_back_to_back;
    logic [7:0] tag;
    logic [9:0] len;
    logic [15:0] rid, tid;
    for (int i = 0; i < 10; i++) begin
      tag = 8'($urandom_range(16, 23));
      if (!m_out[tag] && $urandom_range(0, 3) != 0) do_alloc(tag, 10'($urandom_range(1, 8)));
      len = 10'($urandom_range(1, 4));
      rid = 16'($urandom);
      tid = ($urandom_range(0, 7) == 0) ? ~rid : rid;
      send_cpl(tag, rid, 3'b000, len, tid, $urandom, 3'($urandom), 0, "b2b");
    end
  endtask

  task automatic test_reset_mid;
    int n;
    do_alloc(8'd11, 10'd4);
    lookup_ready = 1'b0;
    @(negedge clk);
    cpl_valid = 1'b1; cpl_tag = 8'd11; cpl_req_id = 16'h0B00; cpl_status = 3'b000; cpl_len = 10'd4;
    n = 0;
    while (cpl_ready_o !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    cpl_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({lookup_valid_o, lookup_tag_o} !== {1'b1, 8'd11}) begin
      miscompares++;
      $display("FAIL rst_mid_lookup: got valid=%0b tag=%0h want valid=1 tag=0b", lookup_valid_o, lookup_tag_o);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({cpl_ready_o, lookup_valid_o, lookup_tag_o, free_valid_o, free_tag_o, out_valid_o, out_tag_o,
         out_addr_o, out_attr_o, out_len_o, out_last_o, out_err_o, out_unexp_o} !== '0) begin
      miscompares++;
      $display("FAIL rst_mid_outputs: got rdy=%0b lkv=%0b lkt=%0h free=%0b v=%0b tag=%0h want all 0",
               cpl_ready_o, lookup_valid_o, lookup_tag_o, free_valid_o, out_valid_o, out_tag_o);
    end
    for (int t = 0; t < 256; t++) m_out[t] = 1'b0;
    n_status = 0; n_id = 0; n_len = 0; n_unexp = 0;
    @(negedge clk);
    rst_n = 1'b1;
    lookup_ready = 1'b1;
    n = 0;
    repeat (4) begin
      @(negedge clk);
      if (free_valid_o === 1'b1 || out_valid_o === 1'b1) n++;
    end
    vectors++;
    if (n !== 0) begin
      miscompares++;
      $display("FAIL rst_mid_discard: got %0d cycles with free/out activity want 0", n);
    end
    send_cpl(8'd11, 16'h0B00, 3'b000, 10'd4, 16'h0B00, 32'hB000_0000, 3'b000, 0, "rst_mid_next");
  endtask

`ifdef TL_CPL_ERR_CNT_EN
  task automatic test_err_cnt;
    vectors++;
    if ({err_cnt_status_o, err_cnt_id_o, err_cnt_len_o, err_cnt_unexp_o} !==
        {16'(n_status), 16'(n_id), 16'(n_len), 16'(n_unexp)}) begin
      miscompares++;
      $display("FAIL err_cnt: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", err_cnt_status_o, err_cnt_id_o,
               err_cnt_len_o, err_cnt_unexp_o, n_status, n_id, n_len, n_unexp);
    end
    @(negedge clk);
    err_cnt_clr = 1'b1;
    @(negedge clk);
    err_cnt_clr = 1'b0;
    vectors++;
    if ({err_cnt_status_o, err_cnt_id_o, err_cnt_len_o, err_cnt_unexp_o} !== '0) begin
      miscompares++;
      $display("FAIL err_cnt_clr: got %0d/%0d/%0d/%0d want 0", err_cnt_status_o, err_cnt_id_o, err_cnt_len_o, err_cnt_unexp_o);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_multi;
    test_1024;
    test_unexp;
    test_errors;
    test_backpressure;
    test_back_to_back;
    test_reset_mid;
    test_errors;
`ifdef TL_CPL_ERR_CNT_EN
    test_err_cnt;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
